// File: rtl/dac_spi_slave_if.sv
// SPI link between the Nios SPI master and the DAC emulator.
// The master drives clock, select and MOSI; the DAC side drives MISO and its enable.
interface dac_spi_slave_if;
  logic spi_SCLK;
  logic spi_SS_n;
  logic spi_MOSI;
  logic spi_MISO;
  logic spi_MISO_oe;

  modport master (
    output spi_SCLK,
    output spi_SS_n,
    output spi_MOSI,
    input  spi_MISO,
    input  spi_MISO_oe
  );

  modport slave (
    input  spi_SCLK,
    input  spi_SS_n,
    input  spi_MOSI,
    output spi_MISO,
    output spi_MISO_oe
  );
endinterface

// File: rtl/dac_spi_slave.sv
// SPI mode-0 DAC emulator: 24-bit {cmd, addr, data} frames into per-channel input
// registers, LDAC copy to output registers, and readback on MISO in the next frame.
module dac_spi_slave #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  dac_spi_slave_if.slave           spi,
  input  logic                     ldac_n,
  output logic [NUM_CH*DATA_W-1:0] dac_val,
  output logic                     dac_upd,
  output logic                     frame_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [1:0] rst_q, rst_d;
  logic       rst_int_n;

  // [0],[1] form the synchronizer, [2] is the delayed copy used for edge detection
  logic [2:0] sclk_q, sclk_d;
  logic [2:0] ss_q, ss_d;
  logic [2:0] mosi_q, mosi_d;
  logic [2:0] ldac_q, ldac_d;

  state_t                          state_q, state_d;
  logic [4:0]                      bit_cnt_q, bit_cnt_d;
  logic [23:0]                     rx_sr_q, rx_sr_d;
  logic [23:0]                     tx_sr_q, tx_sr_d;
  logic                            pend_q, pend_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   in_q, in_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   out_q, out_d;
  logic                            upd_q, upd_d;
  logic                            err_q, err_d;
  logic                            miso_q, miso_d;
  logic                            oe_q, oe_d;

  logic              sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s, ldac_fall_s;
  logic [1:0]        cmd_s;
  logic [5:0]        addr_s;
  logic [DATA_W-1:0] data_s;
  logic [IDX_W-1:0]  ch_idx_s;
  logic              frame_ok_s;

  // Reset synchronizer next-state: shift in ones once reset is released
  always_comb begin
    rst_d = {rst_q[0], 1'b1};
  end

  // Reset synchronizer register: asserts asynchronously, releases on the clock
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_q <= 2'b00;
    end else begin
      rst_q <= rst_d;
    end
  end

  assign rst_int_n = rst_q[1];

  // Input synchronizer chains and edge detectors
  always_comb begin
    sclk_d      = {sclk_q[1:0], spi.spi_SCLK};
    ss_d        = {ss_q[1:0],   spi.spi_SS_n};
    mosi_d      = {mosi_q[1:0], spi.spi_MOSI};
    ldac_d      = {ldac_q[1:0], ldac_n};
    sclk_rise_s =  sclk_q[1] & ~sclk_q[2];
    sclk_fall_s = ~sclk_q[1] &  sclk_q[2];
    ss_fall_s   = ~ss_q[1]   &  ss_q[2];
    ss_rise_s   =  ss_q[1]   & ~ss_q[2];
    ldac_fall_s = ~ldac_q[1] &  ldac_q[2];
  end

  // Frame field decode and validity
  always_comb begin
    cmd_s      = rx_sr_q[23:22];
    addr_s     = rx_sr_q[21:16];
    data_s     = rx_sr_q[DATA_W-1:0];
    ch_idx_s   = addr_s[IDX_W-1:0];
    frame_ok_s = (bit_cnt_q == 5'd24) && ({1'b0, addr_s} < 7'(NUM_CH));
  end

  // FSM next-state, shift registers, register file updates and output pulses
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    pend_d    = pend_q;
    in_d      = in_q;
    out_d     = out_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    miso_d    = 1'b0;
    oe_d      = ~ss_q[1];

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 5'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise_s) begin
          rx_sr_d   = {rx_sr_q[22:0], mosi_q[1]};
          bit_cnt_d = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
        end else begin
          rx_sr_d   = rx_sr_q;
        end
        if (sclk_fall_s && pend_q) begin
          tx_sr_d = {tx_sr_q[22:0], 1'b0};
        end else begin
          tx_sr_d = tx_sr_q;
        end
        if (ss_rise_s) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        if (frame_ok_s) begin
          case (cmd_s)
            2'b01: in_d[ch_idx_s] = data_s;
            2'b10: begin
              tx_sr_d = {2'b10, addr_s, in_q[ch_idx_s]};
              pend_d  = 1'b1;
            end
            2'b11: in_d[ch_idx_s] = data_s;
            default: pend_d = 1'b0;
          endcase
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // LDAC copies pre-commit inputs; a same-cycle cmd 11 then wins for its own channel
    if (ldac_fall_s) begin
      out_d = in_q;
      upd_d = 1'b1;
    end else begin
      out_d = out_q;
    end
    if ((state_q == ST_COMMIT) && frame_ok_s && (cmd_s == 2'b11)) begin
      out_d[ch_idx_s] = data_s;
      upd_d           = 1'b1;
    end else begin
      upd_d = upd_d;
    end

    if ((state_d == ST_SHIFT) && pend_q) begin
      miso_d = tx_sr_d[23];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Synchronizers, FSM state, shift registers, register file and outputs
  always_ff @(posedge clk_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sclk_q    <= 3'b000;
      ss_q      <= 3'b111;
      mosi_q    <= 3'b000;
      ldac_q    <= 3'b111;
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      rx_sr_q   <= 24'd0;
      tx_sr_q   <= 24'd0;
      pend_q    <= 1'b0;
      in_q      <= '0;
      out_q     <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      sclk_q    <= sclk_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      ldac_q    <= ldac_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      pend_q    <= pend_d;
      in_q      <= in_d;
      out_q     <= out_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
    end
  end

  assign dac_val         = out_q;
  assign dac_upd         = upd_q;
  assign frame_err       = err_q;
  assign spi.spi_MISO    = miso_q;
  assign spi.spi_MISO_oe = oe_q;

endmodule

// File: tb/tb_dac_spi_slave.sv
// Directed bench for dac_spi_slave: SPI frames bit-banged at 1/16 of clk,
// expected register contents kept in a small per-channel model.
module tb_dac_spi_slave;
  logic         clk_clk = 1'b0;
  logic         reset_reset_n = 1'b0;
  logic         ldac_n = 1'b1;
  logic [127:0] dac_val;
  logic         dac_upd;
  logic         frame_err;

  dac_spi_slave_if spi_if();

  dac_spi_slave #(.NUM_CH(8), .DATA_W(16)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi           (spi_if),
    .ldac_n        (ldac_n),
    .dac_val       (dac_val),
    .dac_upd       (dac_upd),
    .frame_err     (frame_err)
  );

  always #5 clk_clk = ~clk_clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  logic [15:0] exp_out [8];
  logic [15:0] exp_in  [8];
  logic [23:0] w;
  logic        oe;

  // Pulses last one clk, so a negedge sampler sees each exactly once
  always @(negedge clk_clk) begin
    if (dac_upd === 1'b1) upd_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = exp_out[i];
    return v;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic frame_bits(input logic [31:0] val, input int nbits,
                            output logic [23:0] miso_w, output logic oe_mid);
    miso_w = 24'd0;
    oe_mid = 1'b0;
    spi_if.spi_SS_n = 1'b0;
    clks(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_if.spi_MOSI = val[i];
      clks(4);
      miso_w = {miso_w[22:0], spi_if.spi_MISO};
      oe_mid = spi_if.spi_MISO_oe;
      spi_if.spi_SCLK = 1'b1;
      clks(8);
      spi_if.spi_SCLK = 1'b0;
      clks(4);
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits,
                            output logic [23:0] miso_w, output logic oe_mid);
    frame_bits(val, nbits, miso_w, oe_mid);
    spi_if.spi_SS_n = 1'b1;
    clks(12);
  endtask

  task automatic test_reset();
    clks(4);
    vec_cnt++; if (dac_val !== 128'd0) begin miss_cnt++; $display("FAIL rst_dac_val: got %h want 0", dac_val); end
    vec_cnt++; if (spi_if.spi_MISO !== 1'b0) begin miss_cnt++; $display("FAIL rst_miso: got %b want 0", spi_if.spi_MISO); end
    vec_cnt++; if (spi_if.spi_MISO_oe !== 1'b0) begin miss_cnt++; $display("FAIL rst_oe: got %b want 0", spi_if.spi_MISO_oe); end
    reset_reset_n = 1'b1;
    clks(8);
    vec_cnt++; if (dac_val !== 128'd0) begin miss_cnt++; $display("FAIL post_rst_dac_val: got %h want 0", dac_val); end
    vec_cnt++; if (upd_cnt !== 0 || err_cnt !== 0) begin miss_cnt++; $display("FAIL rst_pulses: got upd=%0d err=%0d want 0/0", upd_cnt, err_cnt); end
  endtask

  task automatic test_write_ldac();
    int u0;
    u0 = upd_cnt;
    send_frame(32'h43A5A5, 24, w, oe);
    exp_in[3] = 16'hA5A5;
    vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL wr_no_output: got %h want %h", dac_val, exp_vec()); end
    vec_cnt++; if (upd_cnt !== u0) begin miss_cnt++; $display("FAIL wr_no_upd: got %0d want %0d", upd_cnt - u0, 0); end
    ldac_n = 1'b0;
    clks(8);
    exp_out[3] = 16'hA5A5;
    vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL ldac_copy: got %h want %h", dac_val, exp_vec()); end
    clks(16);
    vec_cnt++; if (upd_cnt !== u0 + 1) begin miss_cnt++; $display("FAIL ldac_single_upd: got %0d want 1", upd_cnt - u0); end
    ldac_n = 1'b1;
    clks(8);
  endtask

  task automatic test_cmd11_latency();
    int u0;
    u0 = upd_cnt;
    frame_bits(32'hC71234, 24, w, oe);
    spi_if.spi_SS_n = 1'b1;
    clks(3);
    vec_cnt++; if (dac_val[7*16 +: 16] !== 16'h0000) begin miss_cnt++; $display("FAIL c11_before_edge3: got %h want 0000", dac_val[7*16 +: 16]); end
    clks(1);
    exp_in[7] = 16'h1234;
    exp_out[7] = 16'h1234;
    vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL c11_after_edge3: got %h want %h", dac_val, exp_vec()); end
    clks(8);
    vec_cnt++; if (upd_cnt !== u0 + 1) begin miss_cnt++; $display("FAIL c11_upd: got %0d want 1", upd_cnt - u0); end
  endtask

  task automatic test_frame_err();
    logic [31:0] vals [3];
    int          lens [3];
    int          e0, u0;
    vals[0] = 32'h0041BEEF; lens[0] = 23;
    vals[1] = 32'h01C1BEEF; lens[1] = 25;
    vals[2] = 32'h00C8BEEF; lens[2] = 24;
    u0 = upd_cnt;
    for (int k = 0; k < 3; k++) begin
      e0 = err_cnt;
      send_frame(vals[k], lens[k], w, oe);
      vec_cnt++; if (err_cnt !== e0 + 1) begin miss_cnt++; $display("FAIL err_pulse_%0d: got %0d want 1", k, err_cnt - e0); end
      vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL err_regs_%0d: got %h want %h", k, dac_val, exp_vec()); end
    end
    vec_cnt++; if (upd_cnt !== u0) begin miss_cnt++; $display("FAIL err_no_upd: got %0d want 0", upd_cnt - u0); end
    ldac_n = 1'b0;
    clks(8);
    ldac_n = 1'b1;
    clks(8);
    for (int i = 0; i < 8; i++) exp_out[i] = exp_in[i];
    vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL err_inputs_kept: got %h want %h", dac_val, exp_vec()); end
  endtask

  task automatic test_readback();
    int e0;
    e0 = err_cnt;
    send_frame(32'h830000, 24, w, oe);
    vec_cnt++; if (w !== 24'h000000) begin miss_cnt++; $display("FAIL rb_cmd_frame_miso: got %h want 000000", w); end
    vec_cnt++; if (oe !== 1'b1) begin miss_cnt++; $display("FAIL rb_oe_mid: got %b want 1", oe); end
    vec_cnt++; if (spi_if.spi_MISO_oe !== 1'b0) begin miss_cnt++; $display("FAIL rb_oe_idle: got %b want 0", spi_if.spi_MISO_oe); end
    send_frame(32'h000000, 24, w, oe);
    vec_cnt++; if (w !== 24'h83A5A5) begin miss_cnt++; $display("FAIL rb_data: got %h want 83a5a5", w); end
    send_frame(32'h000000, 24, w, oe);
    vec_cnt++; if (w !== 24'h000000) begin miss_cnt++; $display("FAIL rb_cleared: got %h want 000000", w); end
    vec_cnt++; if (err_cnt !== e0) begin miss_cnt++; $display("FAIL rb_no_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_ldac_coincident();
    int u0;
    send_frame(32'h410042, 24, w, oe);
    exp_in[1] = 16'h0042;
    u0 = upd_cnt;
    frame_bits(32'hC0FFFF, 24, w, oe);
    spi_if.spi_SS_n = 1'b1;
    clks(1);
    ldac_n = 1'b0;
    clks(12);
    exp_in[0] = 16'hFFFF;
    for (int i = 0; i < 8; i++) exp_out[i] = exp_in[i];
    vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL coinc_regs: got %h want %h", dac_val, exp_vec()); end
    vec_cnt++; if (upd_cnt !== u0 + 1) begin miss_cnt++; $display("FAIL coinc_upd: got %0d want 1", upd_cnt - u0); end
    ldac_n = 1'b1;
    clks(8);
  endtask

  task automatic test_reset_midframe();
    int e0;
    send_frame(32'h870000, 24, w, oe);
    frame_bits(32'h00000C25, 12, w, oe);
    reset_reset_n = 1'b0;
    clks(2);
    spi_if.spi_SS_n = 1'b1;
    spi_if.spi_SCLK = 1'b0;
    clks(4);
    vec_cnt++; if (dac_val !== 128'd0) begin miss_cnt++; $display("FAIL mid_rst_regs: got %h want 0", dac_val); end
    reset_reset_n = 1'b1;
    clks(8);
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) begin exp_in[i] = 16'h0000; exp_out[i] = 16'h0000; end
    send_frame(32'hC25555, 24, w, oe);
    exp_in[2] = 16'h5555;
    exp_out[2] = 16'h5555;
    vec_cnt++; if (w !== 24'h000000) begin miss_cnt++; $display("FAIL mid_rst_pending: got %h want 000000", w); end
    vec_cnt++; if (dac_val !== exp_vec()) begin miss_cnt++; $display("FAIL mid_rst_clean: got %h want %h", dac_val, exp_vec()); end
    vec_cnt++; if (err_cnt !== e0) begin miss_cnt++; $display("FAIL mid_rst_no_err: got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    spi_if.spi_SCLK = 1'b0;
    spi_if.spi_SS_n = 1'b1;
    spi_if.spi_MOSI = 1'b0;
    for (int i = 0; i < 8; i++) begin exp_in[i] = 16'h0000; exp_out[i] = 16'h0000; end
    test_reset();
    test_write_ldac();
    test_cmd11_latency();
    test_frame_err();
    test_readback();
    test_ldac_coincident();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
